// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Stall/flush sequencer for the 5-stage RV32 pipeline, with fence
//            drain FSM and saturating stall/flush performance counters.
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ID_rs1,
    input  logic [REG_AW-1:0] ID_rs2,
    input  logic              ID_uses_rs1,
    input  logic              ID_uses_rs2,
    input  logic              ID_jalr,
    input  logic              ID_fence,
    input  logic [REG_AW-1:0] ID_EX_rd,
    input  logic              ID_EX_regwrite,
    input  logic              ID_EX_memread,
    input  logic [REG_AW-1:0] EX_MEM_rd,
    input  logic              EX_MEM_memread,
    input  logic              EX_redirect,
    input  logic              ICACHE_stall,
    input  logic              DCACHE_stall,
    output logic              PC_write,
    output logic              IF_ID_write,
    output logic              IF_ID_flush,
    output logic              ID_EX_flush,
    output logic              pipe_freeze,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [0:0] c_ST_RUN     = 1'b0;
    localparam logic [0:0] c_ST_DRAIN   = 1'b1;
    localparam logic [2:0] c_DRAIN_INIT = 3'(DRAIN_CYC - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [2:0]       r_drain_cnt;
    logic [2:0]       w_drain_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall_inc;
    logic             w_flush_inc;

    logic w_lu, w_jx, w_jm, w_haz, w_freeze;
    logic w_fence_start, w_drain_hold, w_bubble;

    // x0 is hardwired zero, so a destination of 0 never creates a dependency
    assign w_lu = ID_EX_memread && (ID_EX_rd != '0) &&
                  ((ID_uses_rs1 && (ID_EX_rd == ID_rs1)) ||
                   (ID_uses_rs2 && (ID_EX_rd == ID_rs2)));
    assign w_jx = ID_jalr && ID_EX_regwrite && (ID_EX_rd != '0) && (ID_EX_rd == ID_rs1);
    assign w_jm = ID_jalr && EX_MEM_memread && (EX_MEM_rd != '0) && (EX_MEM_rd == ID_rs1);
    assign w_haz    = w_lu || w_jx || w_jm;
    assign w_freeze = ICACHE_stall || DCACHE_stall;

    assign w_fence_start = (r_state == c_ST_RUN) && ID_fence;
    assign w_drain_hold  = (r_state == c_ST_DRAIN) && (r_drain_cnt != 3'd0);
    assign w_bubble      = w_haz || w_fence_start || w_drain_hold;

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        w_stall_inc     = 1'b0;
        w_flush_inc     = 1'b0;
        PC_write        = 1'b1;
        IF_ID_write     = 1'b1;
        IF_ID_flush     = 1'b0;
        ID_EX_flush     = 1'b0;
        pipe_freeze     = 1'b0;

        if (rst) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (w_freeze) begin
            pipe_freeze = 1'b1;
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
        end else if (EX_redirect) begin
            // The ID instruction (possibly a draining fence) is squashed
            IF_ID_flush     = 1'b1;
            ID_EX_flush     = 1'b1;
            w_flush_inc     = 1'b1;
            w_state_nxt     = c_ST_RUN;
            w_drain_cnt_nxt = 3'd0;
        end else begin
            if (w_fence_start) begin
                w_state_nxt     = c_ST_DRAIN;
                w_drain_cnt_nxt = c_DRAIN_INIT;
            end else if (w_drain_hold) begin
                w_drain_cnt_nxt = r_drain_cnt - 3'd1;
            end else if ((r_state == c_ST_DRAIN) && !w_haz) begin
                w_state_nxt = c_ST_RUN;
            end

            if (w_bubble) begin
                PC_write    = 1'b0;
                IF_ID_write = 1'b0;
                ID_EX_flush = 1'b1;
                w_stall_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_RUN;
            r_drain_cnt <= 3'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            if (w_stall_inc && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_inc && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign busy      = (r_state == c_ST_DRAIN);
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Randomized and directed self-checking bench for hazard_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int REG_AW    = 5;
    localparam int CNT_W     = 16;
    localparam int DRAIN_CYC = 3;
    localparam int c_CMAX    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] ID_rs1, ID_rs2, ID_EX_rd, EX_MEM_rd;
    logic ID_uses_rs1, ID_uses_rs2, ID_jalr, ID_fence;
    logic ID_EX_regwrite, ID_EX_memread, EX_MEM_memread;
    logic EX_redirect, ICACHE_stall, DCACHE_stall;
    logic PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_freeze, busy;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a fence is "paid" once it has cost DRAIN_CYC bubbles
    bit m_fence_active;
    int m_fence_paid;
    int m_stall;
    int m_flush;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .ID_jalr(ID_jalr), .ID_fence(ID_fence),
        .ID_EX_rd(ID_EX_rd), .ID_EX_regwrite(ID_EX_regwrite), .ID_EX_memread(ID_EX_memread),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_memread(EX_MEM_memread),
        .EX_redirect(EX_redirect), .ICACHE_stall(ICACHE_stall), .DCACHE_stall(DCACHE_stall),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .pipe_freeze(pipe_freeze), .busy(busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ctl_vec();
        return {26'd0, PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_freeze, busy};
    endfunction

    task automatic clr();
        ID_rs1 = '0; ID_rs2 = '0; ID_EX_rd = '0; EX_MEM_rd = '0;
        ID_uses_rs1 = 0; ID_uses_rs2 = 0; ID_jalr = 0; ID_fence = 0;
        ID_EX_regwrite = 0; ID_EX_memread = 0; EX_MEM_memread = 0;
        EX_redirect = 0; ICACHE_stall = 0; DCACHE_stall = 0;
    endtask

    task automatic model_reset();
        m_fence_active = 0; m_fence_paid = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic rand_inputs();
        ID_rs1         = 5'($urandom_range(0, 3));
        ID_rs2         = 5'($urandom_range(0, 3));
        ID_EX_rd       = 5'($urandom_range(0, 3));
        EX_MEM_rd      = 5'($urandom_range(0, 3));
        ID_uses_rs1    = ($urandom_range(0, 9) < 7);
        ID_uses_rs2    = ($urandom_range(0, 9) < 7);
        ID_jalr        = ($urandom_range(0, 9) < 2);
        ID_fence       = ($urandom_range(0, 19) == 0);
        ID_EX_regwrite = ($urandom_range(0, 1) == 1);
        ID_EX_memread  = ($urandom_range(0, 9) < 3);
        EX_MEM_memread = ($urandom_range(0, 9) < 3);
        EX_redirect    = ($urandom_range(0, 11) == 0);
        ICACHE_stall   = ($urandom_range(0, 19) == 0);
        DCACHE_stall   = ($urandom_range(0, 19) == 0);
    endtask

    // Called 1 time unit after a rising edge with inputs already applied.
    task automatic step();
        bit lu, jx, jm, haz, bub;
        logic [5:0] e;
        bit n_active;
        int n_paid, n_stall, n_flush;
        #4;
        lu = ID_EX_memread && ID_EX_rd != 0 &&
             ((ID_uses_rs1 && ID_EX_rd == ID_rs1) || (ID_uses_rs2 && ID_EX_rd == ID_rs2));
        jx = ID_jalr && ID_EX_regwrite && ID_EX_rd != 0 && ID_EX_rd == ID_rs1;
        jm = ID_jalr && EX_MEM_memread && EX_MEM_rd != 0 && EX_MEM_rd == ID_rs1;
        haz = lu || jx || jm;
        n_active = m_fence_active; n_paid = m_fence_paid;
        n_stall = m_stall; n_flush = m_flush;
        // e = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_freeze, busy}
        if (ICACHE_stall || DCACHE_stall) begin
            e = {5'b00001, m_fence_active};
        end else if (EX_redirect) begin
            e = {5'b11110, m_fence_active};
            n_active = 0; n_paid = 0;
            n_flush = (m_flush == c_CMAX) ? c_CMAX : m_flush + 1;
        end else begin
            bub = haz || (!m_fence_active && ID_fence) ||
                  (m_fence_active && m_fence_paid < DRAIN_CYC);
            if (!m_fence_active && ID_fence) begin
                n_active = 1; n_paid = 1;
            end else if (m_fence_active && m_fence_paid < DRAIN_CYC) begin
                n_paid = m_fence_paid + 1;
            end else if (m_fence_active && !haz) begin
                n_active = 0;
            end
            if (bub) begin
                e = {5'b00010, m_fence_active};
                n_stall = (m_stall == c_CMAX) ? c_CMAX : m_stall + 1;
            end else begin
                e = {5'b11000, m_fence_active};
            end
        end
        check("ctl", ctl_vec(), {26'd0, e});
        check("stall_cnt", {16'd0, stall_cnt}, m_stall);
        check("flush_cnt", {16'd0, flush_cnt}, m_flush);
        @(posedge clk);
        m_fence_active = n_active; m_fence_paid = n_paid;
        m_stall = n_stall; m_flush = n_flush;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_ctl", ctl_vec(), 32'b001100);
        check("rst_stall", {16'd0, stall_cnt}, 0);
        check("rst_flush", {16'd0, flush_cnt}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        clr();
        do_reset();

        // Load-use on rs2
        ID_EX_memread = 1; ID_EX_rd = 5; ID_uses_rs2 = 1; ID_rs2 = 5;
        step();
        clr(); step();
        // JALR after load: jx then jm
        ID_jalr = 1; ID_rs1 = 7; ID_EX_regwrite = 1; ID_EX_memread = 1; ID_EX_rd = 7;
        step();
        ID_EX_regwrite = 0; ID_EX_memread = 0; ID_EX_rd = 0; EX_MEM_memread = 1; EX_MEM_rd = 7;
        step();
        EX_MEM_memread = 0; EX_MEM_rd = 0; step();
        // Same with rd=0: no bubble
        ID_EX_regwrite = 1; ID_EX_memread = 1; ID_EX_rd = 0; step();
        clr();
        // Fence with a 2-cycle D-cache stall in the middle
        ID_fence = 1; step(); step();
        DCACHE_stall = 1; step(); step();
        DCACHE_stall = 0; step(); step(); step();
        clr(); step();
        // Redirect in drain with counter at 1
        ID_fence = 1; step(); step();
        EX_redirect = 1; step();
        clr(); step();
        // Freeze masks hazard and redirect, then redirect wins
        ICACHE_stall = 1; EX_redirect = 1;
        ID_EX_memread = 1; ID_EX_rd = 3; ID_uses_rs1 = 1; ID_rs1 = 3;
        step();
        ICACHE_stall = 0; step();
        clr(); step();

        for (int i = 0; i < 2000; i++) begin
            rand_inputs();
            step();
        end

        // Saturate stall_cnt with continuous load-use bubbles
        clr();
        ID_EX_memread = 1; ID_EX_rd = 5; ID_uses_rs2 = 1; ID_rs2 = 5;
        for (int i = 0; i < 70000 && m_stall < c_CMAX; i++) step();
        repeat (5) step();
        check("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);

        // Async reset in the middle of a drain
        clr();
        ID_fence = 1; step();
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_ctl", ctl_vec(), 32'b001100);
        check("async_rst_stall", {16'd0, stall_cnt}, 0);
        check("async_rst_flush", {16'd0, flush_cnt}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clr(); step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
- Consumes register-dependency info from ID, EX and MEM, cache stall requests, and the EX-stage branch redirect.
- Drives PC/IF_ID write enables, IF_ID/ID_EX flushes (bubble insertion) and a global pipeline freeze.
- Sequences multi-cycle fence drains with a small FSM and keeps saturating stall/flush performance counters.

Parameters:
REG_AW, 5, register address width
CNT_W, 16, width of stall_cnt / flush_cnt performance counters
DRAIN_CYC, 3, bubble cycles a fence is held in ID (EX, MEM, WB emptied); legal range 1..7

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
ID_rs1  in  REG_AW  rs1 of instruction in ID
ID_rs2  in  REG_AW  rs2 of instruction in ID
ID_uses_rs1  in  1  ID instruction reads rs1
ID_uses_rs2  in  1  ID instruction reads rs2
ID_jalr  in  1  ID instruction is JALR (target computed in ID)
ID_fence  in  1  ID instruction is FENCE/drain type
ID_EX_rd  in  REG_AW  destination of instruction in EX
ID_EX_regwrite  in  1  EX instruction writes rd
ID_EX_memread  in  1  EX instruction is a load
EX_MEM_rd  in  REG_AW  destination of instruction in MEM
EX_MEM_memread  in  1  MEM instruction is a load
EX_redirect  in  1  EX resolved a taken branch/jump (mispredict), valid only when not frozen
ICACHE_stall  in  1  I-cache miss in progress
DCACHE_stall  in  1  D-cache miss in progress
PC_write  out  1  PC register update enable
IF_ID_write  out  1  IF/ID register update enable
IF_ID_flush  out  1  zero IF/ID (squash fetched instruction)
ID_EX_flush  out  1  load bubble (NOP) into ID/EX
pipe_freeze  out  1  hold every pipeline register and the PC
busy  out  1  FSM in DRAIN
stall_cnt  out  CNT_W  count of bubble cycles inserted
flush_cnt  out  CNT_W  count of redirect flush cycles

Behaviour:
- Reset: state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0. While rst is high: PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=1, pipe_freeze=0, busy=0.
- Outputs are combinational from the registered state and current inputs. State and counters update on the rising clk edge. Zero added latency.
- Hazard terms (rd==0 never matches):
  - lu = ID_EX_memread & ID_EX_rd!=0 & ((ID_uses_rs1 & ID_EX_rd==ID_rs1) | (ID_uses_rs2 & ID_EX_rd==ID_rs2))
  - jx = ID_jalr & ID_EX_regwrite & ID_EX_rd!=0 & ID_EX_rd==ID_rs1 (ALU result not yet forwardable to ID)
  - jm = ID_jalr & EX_MEM_memread & EX_MEM_rd!=0 & EX_MEM_rd==ID_rs1 (load data not yet available)
  - haz = lu | jx | jm
- Priority per cycle, highest first:
  1. freeze = ICACHE_stall | DCACHE_stall. Outputs: pipe_freeze=1, PC_write=0, IF_ID_write=0, no flushes. State, drain counter and perf counters hold.
  2. EX_redirect. Outputs: IF_ID_flush=1, ID_EX_flush=1, PC_write=1, IF_ID_write=1. flush_cnt+1. State -> RUN and drain counter cleared, because the ID instruction is squashed.
  3. Bubble. Applies when haz, or RUN & ID_fence, or DRAIN with counter!=0. Outputs: PC_write=0, IF_ID_write=0, ID_EX_flush=1. stall_cnt+1.
  4. Otherwise: PC_write=1, IF_ID_write=1, all flushes 0.
- JALR after load gives 2 bubbles: jx in cycle 1, jm in cycle 2. This falls out of per-cycle re-evaluation and needs no extra state.
- FSM:
  - RUN -> DRAIN when ID_fence with no freeze and no redirect. Counter loads DRAIN_CYC-1.
  - In DRAIN, each unfrozen cycle with counter!=0: bubble, counter-1.
  - In DRAIN with counter==0 and no haz: release the fence (normal advance), go to RUN. A fence therefore costs exactly DRAIN_CYC bubbles.
  - Redirect in DRAIN -> RUN.
- busy = (state==DRAIN).
- Counters saturate at all-ones with no wrap. Both counters never increment in the same cycle.
- Reset asserted mid-drain or mid-freeze returns to RUN immediately (async). Counters clear.

Test Plan:
- lw x5 in EX (ID_EX_memread=1, rd=5), ID add uses rs2=5 -> exactly 1 cycle PC_write=0, ID_EX_flush=1. Next cycle all enables 1. stall_cnt=1.
- lw x7 in EX, ID jalr rs1=7 -> 2 consecutive bubbles (jx then jm), then advance. stall_cnt=2. Same with rd=0 -> no bubble.
- ID_fence=1 with DRAIN_CYC=3 -> busy=1 for 3 cycles, 3 bubbles, release on 4th cycle. DCACHE_stall=1 for 2 cycles mid-drain extends the fence to 5 cycles with the counter held and pipe_freeze=1.
- EX_redirect=1 during DRAIN with counter=1 -> IF_ID_flush=ID_EX_flush=1, PC_write=1, state RUN, flush_cnt=1, stall_cnt unchanged.
- ICACHE_stall=1 together with lu and EX_redirect -> only pipe_freeze=1, no flush or bubble, no counter change. Drop the stall -> redirect is serviced first.
- Force stall_cnt to 0xFFFF via 65535+ load-use bubbles (CNT_W=16) -> stays 0xFFFF. Assert rst async mid-cycle -> counters 0, IF_ID_flush=1 immediately.
